// File: rtl/el2_dccm_rmw_ctl_if.sv
// Request/response handshake between a debug/DMA requester and el2_dccm_rmw_ctl.
//   master : drives req_valid/req_write/req_addr/req_wdata/req_wstrb, sees req_ready and rsp_*
//   slave  : the sequencer side (inverse directions)
interface el2_dccm_rmw_ctl_if #(
  parameter int unsigned DCCM_BITS = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [DCCM_BITS-1:0] req_addr;
  logic [31:0]          req_wdata;
  logic [3:0]           req_wstrb;
  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_sb_err;
  logic                 rsp_db_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_sb_err, rsp_db_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_sb_err, rsp_db_err
  );
endinterface

// File: rtl/el2_dccm_rmw_ctl.sv
// Single-port request sequencer in front of the DCCM lo port. Word reads are
// ECC-checked/corrected; full-word writes are encoded and written directly;
// partial writes do read -> correct -> merge -> re-encode -> write back.
// Ports:
//   clk, rst_l                 clock, asynchronous active-low reset
//   dec_tlu_core_ecc_disable   1 = use raw read data, suppress error flags
//   req_if (slave)             request handshake + one-cycle response pulse
//   dccm_rden/dccm_wren        DCCM read/write enables (never both)
//   dccm_rd_addr_lo/wr_addr_lo word-aligned DCCM addresses
//   dccm_wr_data_lo            {ecc[6:0], data[31:0]}
//   dccm_rd_data_lo            read data, valid the cycle after dccm_rden
module el2_dccm_rmw_ctl #(
  parameter int unsigned DCCM_BITS        = 16,
  parameter int unsigned DCCM_FDATA_WIDTH = 39
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        dec_tlu_core_ecc_disable,
  el2_dccm_rmw_ctl_if.slave           req_if,
  output logic                        dccm_rden,
  output logic                        dccm_wren,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ECC_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  // SEC-DED encoder: bits 0..5 are Hamming parities, bit 6 is overall parity.
  function automatic logic [ECC_W-1:0] ecc_encode(input logic [DATA_W-1:0] d);
    logic [ECC_W-1:0] e;
    e[0] = ^(d & 32'h56AA_AD5B);
    e[1] = ^(d & 32'h9B33_366D);
    e[2] = ^(d & 32'hE3C3_C78E);
    e[3] = ^(d & 32'h03FC_07F0);
    e[4] = ^(d & 32'h03FF_F800);
    e[5] = ^(d & 32'hFC00_0000);
    e[6] = ^{d, e[5:0]};
    return e;
  endfunction

  // Hamming codeword position (1-based) of data bit i; powers of two hold parity.
  function automatic logic [5:0] data_pos(input int i);
    if (i == 0)       return 6'd3;
    else if (i < 4)   return 6'(i + 4);
    else if (i < 11)  return 6'(i + 5);
    else if (i < 26)  return 6'(i + 6);
    else              return 6'(i + 7);
  endfunction

  // Flip the data bit whose codeword position equals the syndrome.
  function automatic logic [DATA_W-1:0] ecc_flip(input logic [DATA_W-1:0] d,
                                                  input logic [5:0]        syn);
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < 32; i++) begin
      if (syn == data_pos(i)) r[5'(i)] = ~r[5'(i)];
    end
    return r;
  endfunction

  // Byte-lane merge of new write data over the corrected stored word.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_d,
                                                    input logic [DATA_W-1:0] new_d,
                                                    input logic [3:0]        strb);
    logic [DATA_W-1:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
    end
    return r;
  endfunction

  state_t state_q, state_nx;

  logic                        req_rd_q, req_rd_nx;
  logic [DATA_W-1:0]           wdata_q, wdata_nx;
  logic [3:0]                  wstrb_q, wstrb_nx;
  logic                        sb_q, sb_nx;

  logic                        req_ready_q, req_ready_nx;
  logic                        rsp_valid_q, rsp_valid_nx;
  logic [DATA_W-1:0]           rsp_rdata_q, rsp_rdata_nx;
  logic                        rsp_sb_q, rsp_sb_nx;
  logic                        rsp_db_q, rsp_db_nx;
  logic                        rden_q, rden_nx;
  logic                        wren_q, wren_nx;
  logic [DCCM_BITS-1:0]        rd_addr_q, rd_addr_nx;
  logic [DCCM_BITS-1:0]        wr_addr_q, wr_addr_nx;
  logic [DCCM_FDATA_WIDTH-1:0] wr_data_q, wr_data_nx;

  // Read-side decode of the word returned by the DCCM.
  logic [DATA_W-1:0] rd_word_c;
  logic [ECC_W-1:0]  rd_ecc_c;
  logic [ECC_W-1:0]  rd_calc_c;
  logic [5:0]        syn_c;
  logic              par_c;
  logic              dec_en_c;
  logic              sb_err_c;
  logic              db_err_c;
  logic [DATA_W-1:0] dec_data_c;
  logic [DATA_W-1:0] merged_c;
  logic [DCCM_BITS-1:0] req_addr_al_c;
  logic              req_full_c;
  logic              unused_addr_lsb;

  assign rd_word_c  = dccm_rd_data_lo[DATA_W-1:0];
  assign rd_ecc_c   = dccm_rd_data_lo[DATA_W +: ECC_W];
  assign rd_calc_c  = ecc_encode(rd_word_c);
  assign syn_c      = rd_ecc_c[5:0] ^ rd_calc_c[5:0];
  assign par_c      = ^{rd_word_c, rd_ecc_c};
  assign dec_en_c   = ~dec_tlu_core_ecc_disable;
  // Odd overall parity = single error (possibly in a check bit); even parity
  // with a nonzero syndrome = double error.
  assign sb_err_c   = dec_en_c & par_c;
  assign db_err_c   = dec_en_c & ~par_c & (syn_c != 6'd0);
  assign dec_data_c = sb_err_c ? ecc_flip(rd_word_c, syn_c) : rd_word_c;
  assign merged_c   = byte_merge(dec_data_c, wdata_q, wstrb_q);

  assign req_addr_al_c   = {req_if.req_addr[DCCM_BITS-1:2], 2'b00};
  assign req_full_c      = req_if.req_write & (req_if.req_wstrb == 4'hF);
  assign unused_addr_lsb = ^req_if.req_addr[1:0];

  // Next-state and next-output decode.
  always_comb begin
    state_nx     = state_q;
    req_rd_nx    = req_rd_q;
    wdata_nx     = wdata_q;
    wstrb_nx     = wstrb_q;
    sb_nx        = sb_q;
    rden_nx      = 1'b0;
    wren_nx      = 1'b0;
    rd_addr_nx   = rd_addr_q;
    wr_addr_nx   = wr_addr_q;
    wr_data_nx   = wr_data_q;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = '0;
    rsp_sb_nx    = 1'b0;
    rsp_db_nx    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_if.req_valid) begin
          // A write with no byte enables is handled as a read.
          req_rd_nx  = ~req_if.req_write | (req_if.req_wstrb == 4'h0);
          wdata_nx   = req_if.req_wdata;
          wstrb_nx   = req_if.req_wstrb;
          sb_nx      = 1'b0;
          rd_addr_nx = req_addr_al_c;
          wr_addr_nx = req_addr_al_c;
          if (req_full_c) begin
            state_nx   = ST_WR;
            wren_nx    = 1'b1;
            wr_data_nx = {ecc_encode(req_if.req_wdata), req_if.req_wdata};
          end else begin
            state_nx = ST_RD;
            rden_nx  = 1'b1;
          end
        end
      end
      ST_RD: begin
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (req_rd_q) begin
          state_nx     = ST_IDLE;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = dec_data_c;
          rsp_sb_nx    = sb_err_c;
          rsp_db_nx    = db_err_c;
        end else if (db_err_c) begin
          // Uncorrectable word: never write back merged garbage.
          state_nx     = ST_IDLE;
          rsp_valid_nx = 1'b1;
          rsp_db_nx    = 1'b1;
        end else begin
          state_nx   = ST_WR;
          wren_nx    = 1'b1;
          sb_nx      = sb_err_c;
          wr_data_nx = {ecc_encode(merged_c), merged_c};
        end
      end
      ST_WR: begin
        state_nx     = ST_IDLE;
        rsp_valid_nx = 1'b1;
        rsp_sb_nx    = sb_q;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign req_ready_nx = (state_nx == ST_IDLE);

  // State, request and output registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      req_rd_q    <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      sb_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_sb_q    <= 1'b0;
      rsp_db_q    <= 1'b0;
      rden_q      <= 1'b0;
      wren_q      <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_nx;
      req_rd_q    <= req_rd_nx;
      wdata_q     <= wdata_nx;
      wstrb_q     <= wstrb_nx;
      sb_q        <= sb_nx;
      req_ready_q <= req_ready_nx;
      rsp_valid_q <= rsp_valid_nx;
      rsp_rdata_q <= rsp_rdata_nx;
      rsp_sb_q    <= rsp_sb_nx;
      rsp_db_q    <= rsp_db_nx;
      rden_q      <= rden_nx;
      wren_q      <= wren_nx;
      rd_addr_q   <= rd_addr_nx;
      wr_addr_q   <= wr_addr_nx;
      wr_data_q   <= wr_data_nx;
    end
  end

  assign req_if.req_ready  = req_ready_q;
  assign req_if.rsp_valid  = rsp_valid_q;
  assign req_if.rsp_rdata  = rsp_rdata_q;
  assign req_if.rsp_sb_err = rsp_sb_q;
  assign req_if.rsp_db_err = rsp_db_q;
  assign dccm_rden         = rden_q;
  assign dccm_wren         = wren_q;
  assign dccm_rd_addr_lo   = rd_addr_q;
  assign dccm_wr_addr_lo   = wr_addr_q;
  assign dccm_wr_data_lo   = wr_data_q;

endmodule

// File: tb/tb_el2_dccm_rmw_ctl.sv
// Directed bench for el2_dccm_rmw_ctl: vector table of single transactions
// against a small DCCM model, plus a reset-during-RMW sequence.
module tb_el2_dccm_rmw_ctl;

  localparam int unsigned DB = 16;
  localparam int unsigned FW = 39;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          ecc_dis;
  logic          rden, wren;
  logic [DB-1:0] rd_addr, wr_addr;
  logic [FW-1:0] wr_data, rd_data;

  always #5 clk = ~clk;

  el2_dccm_rmw_ctl_if #(.DCCM_BITS(DB)) bus ();

  el2_dccm_rmw_ctl #(.DCCM_BITS(DB), .DCCM_FDATA_WIDTH(FW)) dut (
    .clk                      (clk),
    .rst_l                    (rst_l),
    .dec_tlu_core_ecc_disable (ecc_dis),
    .req_if                   (bus),
    .dccm_rden                (rden),
    .dccm_wren                (wren),
    .dccm_rd_addr_lo          (rd_addr),
    .dccm_wr_addr_lo          (wr_addr),
    .dccm_wr_data_lo          (wr_data),
    .dccm_rd_data_lo          (rd_data)
  );

  // DCCM model: 256 words, one-cycle read latency, preload port for the bench.
  logic [FW-1:0] mem [256];
  logic          pl_en;
  logic [7:0]    pl_idx;
  logic [FW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (rden)  rd_data <= mem[rd_addr[9:2]];
    if (wren)  mem[wr_addr[9:2]] <= wr_data;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference SEC-DED check bits built from the Hamming layout: data bits fill
  // the non-power-of-two positions 3,5,6,7,9.. in order.
  function automatic logic [6:0] tb_ecc(input logic [31:0] d);
    logic [6:0] e;
    int di;
    e  = '0;
    di = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int k = 0; k < 6; k++) begin
          if (((p >> k) & 1) != 0) e[k] = e[k] ^ d[5'(di)];
        end
        di++;
      end
    end
    e[6] = ^{d, e[5:0]};
    return e;
  endfunction

  typedef struct {
    logic        dis;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] init;
    logic [38:0] flip;
    int          rden_c;
    int          wren_c;
    int          rsp_c;
    logic [31:0] rdata;
    logic        sb;
    logic        db;
    logic [31:0] mem_after;
    logic        keep;
  } vec_t;

  vec_t vt [11];

  task automatic preload(input logic [7:0] idx, input logic [38:0] data);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [38:0] init;
    logic [38:0] exp_mem;
    logic [15:0] al;
    int rden_c, wren_c, rsp_c, both;
    logic [31:0] rdata;
    logic sb, db, noisy;
    string tag;
    tag    = $sformatf("v%0d", n);
    init   = {tb_ecc(v.init), v.init} ^ v.flip;
    al     = {v.addr[15:2], 2'b00};
    rden_c = 0; wren_c = 0; rsp_c = 0; both = 0;
    rdata  = '0; sb = 1'b0; db = 1'b0; noisy = 1'b0;
    preload(v.addr[9:2], init);
    ecc_dis = v.dis;
    check({tag, "_ready"}, 64'(bus.req_ready), 64'(1));
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_wstrb = v.strb;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'hFFFF_FFFF;
      end
      if (rden && wren) both++;
      if (rden) begin
        rden_c = c;
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'(al));
      end
      if (wren) begin
        wren_c = c;
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'(al));
        check({tag, "_wr_data"}, 64'(wr_data), 64'({tb_ecc(v.mem_after), v.mem_after}));
      end
      if (bus.rsp_valid) begin
        rsp_c = c;
        rdata = bus.rsp_rdata;
        sb    = bus.rsp_sb_err;
        db    = bus.rsp_db_err;
        check({tag, "_ready_at_rsp"}, 64'(bus.req_ready), 64'(1));
      end else if (bus.rsp_rdata != 32'h0 || bus.rsp_sb_err || bus.rsp_db_err) begin
        noisy = 1'b1;
      end
    end
    exp_mem = v.keep ? init : {tb_ecc(v.mem_after), v.mem_after};
    check({tag, "_rden_cycle"}, 64'(rden_c), 64'(v.rden_c));
    check({tag, "_wren_cycle"}, 64'(wren_c), 64'(v.wren_c));
    check({tag, "_rsp_cycle"},  64'(rsp_c),  64'(v.rsp_c));
    check({tag, "_rdata"},      64'(rdata),  64'(v.rdata));
    check({tag, "_sb"},         64'(sb),     64'(v.sb));
    check({tag, "_db"},         64'(db),     64'(v.db));
    check({tag, "_rden_wren_overlap"}, 64'(both), 64'(0));
    check({tag, "_rsp_quiet"},  64'(noisy),  64'(0));
    check({tag, "_mem"},        64'(mem[v.addr[9:2]]), 64'(exp_mem));
  endtask

  initial begin
    int late;
    logic [38:0] rst_init;
    //        dis   wr    addr      wdata          strb   init           flip          rd wr rsp rdata         sb    db    mem_after      keep
    vt[0]  = '{1'b0, 1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 32'h0,        39'h0,         0, 1, 2, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 16'h0040, 32'h0,        4'h0, 32'hDEADBEEF, 39'h0,         1, 0, 3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b1};
    vt[2]  = '{1'b0, 1'b1, 16'h0042, 32'h00AA0000, 4'h4, 32'h11223344, 39'h0,         1, 3, 4, 32'h0,        1'b0, 1'b0, 32'h11AA3344, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 16'h0080, 32'h0,        4'h0, 32'h11223344, 39'h20,        1, 0, 3, 32'h11223344, 1'b1, 1'b0, 32'h0,        1'b1};
    vt[4]  = '{1'b1, 1'b0, 16'h0080, 32'h0,        4'h0, 32'h11223344, 39'h20,        1, 0, 3, 32'h11223364, 1'b0, 1'b0, 32'h0,        1'b1};
    vt[5]  = '{1'b0, 1'b1, 16'h00C0, 32'h0000FF00, 4'h2, 32'h11223344, 39'h101,       1, 0, 3, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
    vt[6]  = '{1'b0, 1'b1, 16'h0100, 32'h12345678, 4'h0, 32'hCAFEF00D, 39'h0,         1, 0, 3, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        1'b1};
    vt[7]  = '{1'b0, 1'b1, 16'h0144, 32'h000000FF, 4'h1, 32'hA5A5A5A5, 39'h40000000,  1, 3, 4, 32'h0,        1'b1, 1'b0, 32'hA5A5A5FF, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 16'h0180, 32'h0,        4'h0, 32'h0F0F0F0F, 39'h400000000, 1, 0, 3, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h0,        1'b1};
    vt[9]  = '{1'b0, 1'b1, 16'hFFFE, 32'h87654321, 4'hF, 32'h0,        39'h0,         0, 1, 2, 32'h0,        1'b0, 1'b0, 32'h87654321, 1'b0};
    vt[10] = '{1'b1, 1'b1, 16'h01C0, 32'hAB000000, 4'h8, 32'h11223344, 39'h101,       1, 3, 4, 32'h0,        1'b0, 1'b0, 32'hAB223245, 1'b0};

    rst_l         = 1'b0;
    ecc_dis       = 1'b0;
    pl_en         = 1'b0;
    pl_idx        = '0;
    pl_data       = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;

    repeat (2) @(negedge clk);
    check("reset_ready",     64'(bus.req_ready), 64'(1));
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("reset_rden_wren", 64'({rden, wren}),  64'(0));
    check("reset_wr_data",   64'(wr_data),       64'(0));
    check("reset_addrs",     64'({rd_addr, wr_addr}), 64'(0));
    rst_l = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(i, vt[i]);

    // Reset during WAIT of a partial write: the pending write must vanish.
    ecc_dis  = 1'b0;
    rst_init = {tb_ecc(32'h01020304), 32'h01020304};
    preload(8'h50, rst_init);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h0140;
    bus.req_wdata = 32'h000000FF;
    bus.req_wstrb = 4'h1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    check("rst_mid_wren",      64'(wren),           64'(0));
    check("rst_mid_rsp_valid", 64'(bus.rsp_valid),  64'(0));
    check("rst_mid_ready",     64'(bus.req_ready),  64'(1));
    @(negedge clk);
    check("rst_hold_outputs", 64'({rden, wren, bus.rsp_valid, bus.rsp_sb_err, bus.rsp_db_err}), 64'(0));
    rst_l = 1'b1;
    late = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (wren || bus.rsp_valid) late++;
    end
    check("rst_no_late_activity", 64'(late), 64'(0));
    check("rst_mem_unchanged",    64'(mem[8'h50]), 64'(rst_init));
    run_vec(11, '{1'b0, 1'b0, 16'h0140, 32'h0, 4'h0, 32'h01020304, 39'h0,
                  1, 0, 3, 32'h01020304, 1'b0, 1'b0, 32'h0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
